// File: rtl/aer_pkg.sv
// Shared AER event layout, size limits and the round-robin winner search used by the
// event arbiter.
package aer_pkg;

   localparam int unsigned CH_W     = 4;
   localparam int unsigned TS_W     = 20;
   localparam int unsigned AER_W    = CH_W + TS_W;
   localparam int unsigned MAX_REQ  = 16;
   localparam int unsigned RR_IDX_W = 4;

   typedef struct packed {
      logic [CH_W-1:0] ch;
      logic [TS_W-1:0] ts;
   } aer_event_t;

   // Returns the first requester found after ptr, wrapping modulo num_req.
   function automatic logic [RR_IDX_W-1:0] rr_winner(
      input logic [MAX_REQ-1:0]  req,
      input logic [RR_IDX_W-1:0] ptr,
      input int unsigned         num_req
   );
      logic [RR_IDX_W-1:0] win;
      logic                found;
      int unsigned         idx;
      win   = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= MAX_REQ; k++) begin
         idx = (32'(ptr) + k) % num_req;
         if (k <= num_req && !found && req[idx[RR_IDX_W-1:0]]) begin
            found = 1'b1;
            win   = idx[RR_IDX_W-1:0];
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant and grant index for the first
// requester after the pointer. The pointer register lives in the parent.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any_req
);
   import aer_pkg::*;

   logic [MAX_REQ-1:0]  req_ext;
   logic [RR_IDX_W-1:0] win;

   always_comb begin
      req_ext                = '0;
      req_ext[NUM_REQ-1:0]   = req;
      win                    = rr_winner(req_ext, RR_IDX_W'(ptr), NUM_REQ);
      any_req                = |req;
      grant_idx              = IDX_W'(win);
      grant                  = '0;
      if (any_req) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/aer_event_arbiter.sv
// Round-robin merge of NUM_REQ AER sources into one registered event/valid/ready output.
// Define AER_ARB_TS_STAMP_EN to overwrite the timestamp field with a local cycle counter.
module aer_event_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned CH_W    = 4,
   parameter int unsigned TS_W    = 20,
   parameter int unsigned AER_W   = 24,
   localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*AER_W-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [AER_W-1:0]         aer_out,
   output logic                     aer_valid,
   input  logic                     aer_ready,
   output logic [IDX_W-1:0]         grant_id,
   output logic                     busy
);
   import aer_pkg::*;

   logic [IDX_W-1:0]   ptr_q;
   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   win_idx;
   logic               any_req;
   logic               out_free;
   logic               accept;
   logic [AER_W-1:0]   win_data;
   logic [AER_W-1:0]   load_word;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req       (req_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (win_idx),
      .any_req   (any_req)
   );

   assign out_free  = !aer_valid || aer_ready;
   // No accept strobe while reset is held, so nothing is consumed and then discarded.
   assign req_ready = (!rst && out_free && any_req) ? grant : '0;
   assign accept    = |req_ready;
   assign win_data  = req_data[32'(win_idx)*AER_W +: AER_W];
   assign busy      = !rst && (aer_valid || (|req_valid));

`ifdef AER_ARB_TS_STAMP_EN
   logic [TS_W-1:0] ts_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
      end
   end

   assign load_word = {win_data[AER_W-1:TS_W], ts_q};
`else
   assign load_word = win_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         aer_out   <= '0;
         aer_valid <= 1'b0;
         grant_id  <= '0;
         ptr_q     <= IDX_W'(NUM_REQ - 1);
      end else if (accept) begin
         aer_out   <= load_word;
         aer_valid <= 1'b1;
         grant_id  <= win_idx;
         ptr_q     <= win_idx;
      end else if (aer_ready) begin
         aer_valid <= 1'b0;
      end
   end

   a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

   a_stall_hold: assert property (@(posedge clk) disable iff (rst)
      (aer_valid && !aer_ready) |=> (aer_valid && $stable(aer_out) && $stable(grant_id)));

endmodule

// File: doc/aer_event_arbiter.md
Name: aer_event_arbiter

Overview:
- Shares the single AER event input of the neural accelerator's input decoder between NUM_REQ spike sources (cochlea channel groups).
- Sources present 24-bit AER words: channel id in [23:20], timestamp in [19:0].
- Round-robin arbitration; one winner per cycle is moved into a one-entry output register.
- The output register drives the decoder's event/valid pair under a ready handshake.

Parameters:
- NUM_REQ, 4: number of requesting sources (2..16).
- CH_W, 4: channel id field width.
- TS_W, 20: timestamp field width.
- AER_W, 24: event word width; must equal CH_W+TS_W.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-source event pending.
- req_data  input  NUM_REQ*AER_W  per-source event word; source i occupies bits [i*AER_W +: AER_W].
- req_ready  output  NUM_REQ  one-hot accept strobe; source i's event is consumed when req_valid[i] and req_ready[i] are both high.
- aer_out  output  AER_W  event word to the decoder.
- aer_valid  output  1  aer_out holds a valid event.
- aer_ready  input  1  decoder accepts; tie high when the decoder has no backpressure.
- grant_id  output  clog2(NUM_REQ)  index of the source whose event is currently in aer_out.
- busy  output  1  high when aer_valid is high or any req_valid bit is high.

Behaviour:
- Reset values: aer_out=0, aer_valid=0, grant_id=0, round-robin pointer=NUM_REQ-1 (so source 0 has first priority), req_ready=0, busy=0 during the reset cycle.
- out_free = !aer_valid || aer_ready.
- Arbitration (combinational): search order is ptr+1, ptr+2, ... wrapping modulo NUM_REQ. The first i with req_valid[i] is the winner. req_ready = onehot(winner) when out_free and any req is valid; otherwise 0. At most one req_ready bit is ever high.
- Accept cycle t (any req_ready bit high), at the posedge:
  - aer_out <= req_data[winner]
  - aer_valid <= 1
  - grant_id <= winner
  - ptr <= winner
  - Latency: aer_valid is high in cycle t+1.
- Drain: if aer_valid && aer_ready and there is no accept in the same cycle, aer_valid <= 0 at the posedge.
- Simultaneous drain and accept (aer_valid && aer_ready with a winner present): the register reloads in the same posedge. Sustained throughput is 1 event/cycle.
- Stall: while aer_valid && !aer_ready, aer_out and grant_id are held stable and req_ready=0. Requesters must hold req_valid and req_data stable until accepted.
- Fairness: a continuously requesting source waits at most NUM_REQ-1 grants.
- Reset mid-operation: any event in aer_out is discarded, ptr is reset, and no req_ready is asserted in the reset cycle.
- No modification of the event word except under the optional feature. The channel field passes through unchanged.

Optional Feature:
- Macro AER_ARB_TS_STAMP_EN.
- Defined:
  - A free-running TS_W-bit counter increments every cycle after reset, wrapping from 2^TS_W-1 to 0; reset value 0.
  - On accept, aer_out[TS_W-1:0] <= counter value in the accept cycle, and aer_out[AER_W-1:TS_W] <= req_data[winner][AER_W-1:TS_W].
- Undefined: the counter is absent and the full req_data word passes through.

Decomposition:
- Shared package aer_pkg:
  - Constants AER_W, CH_W, TS_W.
  - Typedef aer_event_t as a packed struct {ch, ts}.
  - Function returning the round-robin winner index from a request vector and pointer.
- Natural sub-module rr_arbiter: purely combinational; inputs request vector and pointer; outputs one-hot grant and grant index. The parent owns the pointer register and the output register.

Test Plan:
- Single source: req_valid=4'b0001, req_data[0]=24'h3_00010, aer_ready=1. Expected: req_ready=4'b0001 in cycle t; aer_out=24'h300010, aer_valid=1, grant_id=0 in t+1.
- All four sources requesting continuously, aer_ready=1. Expected: grant order 0,1,2,3,0,1; one event per cycle; no duplicate or lost words.
- Backpressure: aer_valid=1, aer_ready=0 held for 5 cycles. Expected: aer_out and grant_id stable, req_ready=0; on aer_ready=1 the next winner loads in the same posedge.
- Pointer wrap: ptr=3 and req_valid=4'b1001. Expected: source 0 is granted before source 3.
- Reset asserted while aer_valid=1 with requests pending. Expected: next cycle aer_valid=0, req_ready=0, ptr=3; after reset deasserts, source 0 wins first.
- With AER_ARB_TS_STAMP_EN defined: accept in the 5th cycle after reset with req_data=24'hA_FFFFF. Expected: aer_out=24'hA_00004. Also run past 2^20 cycles and check the timestamp wraps to 0.
